// File: rtl/cp0_reg_pkg.sv
// cp0_defs: shared definitions for the CP0 register block.
//   - CP0 register numbers as seen by mtc0/mfc0
//   - exception type codes delivered by the MEM/WB stage
//   - mtc0 write masks for Status and Cause
//   - helpers to classify exception types and derive ExcCode
package cp0_defs;

  typedef enum logic [4:0] {
    BADVADDR = 5'd8,
    COUNT    = 5'd9,
    COMPARE  = 5'd11,
    STATUS   = 5'd12,
    CAUSE    = 5'd13,
    EPC      = 5'd14
  } cp0_addr_e;

  localparam logic [31:0] INT  = 32'd1;
  localparam logic [31:0] ADEL = 32'd4;
  localparam logic [31:0] ADES = 32'd5;
  localparam logic [31:0] SYS  = 32'd8;
  localparam logic [31:0] BP   = 32'd9;
  localparam logic [31:0] RI   = 32'd10;
  localparam logic [31:0] OV   = 32'd12;
  localparam logic [31:0] ERET = 32'd14;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;

  // True for every code that enters the exception handler (ERET excluded).
  function automatic logic is_fault(input logic [31:0] t);
    case (t)
      INT, ADEL, ADES, SYS, BP, RI, OV: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // Interrupts report ExcCode 0 even though their type code is 1.
  function automatic logic [4:0] exc_code(input logic [31:0] t);
    return (t == INT) ? 5'd0 : t[4:0];
  endfunction

  function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer for CP0.
//   clk, reset        clock, async active-high reset
//   count_we          mtc0 write to Count (already qualified)
//   compare_we        mtc0 write to Compare (already qualified)
//   wdata             mtc0 data
//   count, compare    current register values
//   timer_int         sticky timer interrupt, cleared by a Compare write
module cp0_timer #(
  parameter int TICK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick;

  // A Count write restarts the divider so the next increment lands a full
  // TICK_DIV cycles after the written value becomes visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= '0;
    end else if (count_we) begin
      count <= wdata;
      tick  <= '0;
    end else if (tick == TICK_LAST) begin
      count <= count + 32'd1;
      tick  <= '0;
    end else begin
      tick  <= tick + 1'b1;
    end
  end

  // Compare write wins over a match in the same cycle, even if the written
  // value equals count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare   <= '0;
      timer_int <= 1'b0;
    end else if (compare_we) begin
      compare   <= wdata;
      timer_int <= 1'b0;
    end else if ((count == compare) && (compare != 32'd0)) begin
      timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: Coprocessor-0 register block at the writeback end of the pipe.
//   clk, reset     clock, async active-high reset
//   i_we/i_waddr/i_wdata   mtc0 write from MEM/WB
//   i_raddr        mfc0 source register (read is combinational)
//   i_int          level-sensitive hardware interrupt lines
//   i_except/i_pc/i_bd/i_bad_vaddr   exception info from MEM/WB
//   o_rdata        mfc0 data with same-cycle mtc0 forwarding
//   o_status/o_cause/o_epc   forwarded register views for MEM/ERET
//   o_timer_int    timer interrupt pending
module cp0_reg
  import cp0_defs::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          TICK_DIV   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr,
  input  logic [5:0]  i_int,
  input  logic [31:0] i_except,
  input  logic [31:0] i_pc,
  input  logic        i_bd,
  input  logic [31:0] i_bad_vaddr,
  output logic [31:0] o_rdata,
  output logic [31:0] o_status,
  output logic [31:0] o_cause,
  output logic [31:0] o_epc,
  output logic        o_timer_int
);

  logic [31:0] status, cause, epc, badvaddr;
  logic [31:0] count, compare;
  logic        timer_int;

  logic fault, eret, wr_ok;
  logic we_count, we_compare, we_status, we_cause, we_epc;
  logic [31:0] status_fwd, cause_fwd, epc_fwd;

  // Any exception or ERET drops the mtc0 in the same cycle.
  assign fault = is_fault(i_except);
  assign eret  = (i_except == ERET);
  assign wr_ok = i_we & ~fault & ~eret;

  assign we_count   = wr_ok && (i_waddr == COUNT);
  assign we_compare = wr_ok && (i_waddr == COMPARE);
  assign we_status  = wr_ok && (i_waddr == STATUS);
  assign we_cause   = wr_ok && (i_waddr == CAUSE);
  assign we_epc     = wr_ok && (i_waddr == EPC);

  assign status_fwd = we_status ? wmerge(status, i_wdata, STATUS_WMASK) : status;
  assign cause_fwd  = we_cause  ? wmerge(cause,  i_wdata, CAUSE_WMASK)  : cause;
  assign epc_fwd    = we_epc    ? i_wdata : epc;

  cp0_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (we_count),
    .compare_we (we_compare),
    .wdata      (i_wdata),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status   <= STATUS_RST;
      cause    <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      // IP[7:2]; the timer shares the IP7 line with i_int[5].
      cause[15:10] <= {i_int[5] | timer_int, i_int[4:0]};
      if (fault) begin
        // Nested exceptions keep the original EPC/BD so the outer handler
        // can still return.
        if (!status[STATUS_EXL]) begin
          epc             <= i_bd ? (i_pc - 32'd4) : i_pc;
          cause[CAUSE_BD] <= i_bd;
        end
        status[STATUS_EXL] <= 1'b1;
        cause[6:2]         <= exc_code(i_except);
        if ((i_except == ADEL) || (i_except == ADES))
          badvaddr <= i_bad_vaddr;
      end else if (eret) begin
        status[STATUS_EXL] <= 1'b0;
      end else begin
        if (we_status) status     <= status_fwd;
        if (we_cause)  cause[9:8] <= i_wdata[9:8];
        if (we_epc)    epc        <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_raddr)
      BADVADDR: o_rdata = badvaddr;
      COUNT:    o_rdata = we_count ? i_wdata : count;
      COMPARE:  o_rdata = we_compare ? i_wdata : compare;
      STATUS:   o_rdata = status_fwd;
      CAUSE:    o_rdata = cause_fwd;
      EPC:      o_rdata = epc_fwd;
      default:  o_rdata = '0;
    endcase
  end

  assign o_status    = status_fwd;
  assign o_cause     = cause_fwd;
  assign o_epc       = epc_fwd;
  assign o_timer_int = timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
module tb_cp0_reg;

  localparam int TICK_DIV = 2;
  localparam logic [4:0] A_BAD = 5'd8, A_CNT = 5'd9, A_CMP = 5'd11,
                         A_ST = 5'd12, A_CA = 5'd13, A_EPC = 5'd14;
  localparam logic [31:0] T_INT = 1, T_ADEL = 4, T_ADES = 5, T_SYS = 8,
                          T_BP = 9, T_RI = 10, T_OV = 12, T_ERET = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_we;
  logic [4:0]  i_waddr, i_raddr;
  logic [31:0] i_wdata, i_except, i_pc, i_bad_vaddr;
  logic [5:0]  i_int;
  logic        i_bd;
  logic [31:0] o_rdata, o_status, o_cause, o_epc;
  logic        o_timer_int;

  always #5 clk = ~clk;

  cp0_reg #(.STATUS_RST(32'h0040_0000), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .i_we(i_we), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_raddr(i_raddr), .i_int(i_int),
    .i_except(i_except), .i_pc(i_pc), .i_bd(i_bd),
    .i_bad_vaddr(i_bad_vaddr), .o_rdata(o_rdata), .o_status(o_status),
    .o_cause(o_cause), .o_epc(o_epc), .o_timer_int(o_timer_int)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: Count is derived from elapsed cycles since the last
  // reset or Count write rather than stepped like a register.
  logic [31:0] m_cnt_base;
  int          m_ticks;
  logic [31:0] m_cmp, m_st, m_ca, m_epc, m_bad;
  logic        m_tint;

  function automatic logic [31:0] m_count();
    return m_cnt_base + 32'(m_ticks / TICK_DIV);
  endfunction

  function automatic bit m_fault(input logic [31:0] t);
    return t inside {T_INT, T_ADEL, T_ADES, T_SYS, T_BP, T_RI, T_OV};
  endfunction

  function automatic bit m_wr_to(input logic [4:0] a);
    return i_we && !m_fault(i_except) && (i_except != T_ERET) && (i_waddr == a);
  endfunction

  // Architectural view of a register, including same-cycle mtc0 forwarding.
  function automatic logic [31:0] m_view(input logic [4:0] a);
    logic [31:0] v;
    bit wr;
    wr = m_wr_to(a);
    case (a)
      A_BAD:   v = m_bad;
      A_CNT:   v = wr ? i_wdata : m_count();
      A_CMP:   v = wr ? i_wdata : m_cmp;
      A_ST:    v = wr ? {m_st[31:16], i_wdata[15:8], m_st[7:2], i_wdata[1:0]} : m_st;
      A_CA:    v = wr ? {m_ca[31:10], i_wdata[9:8], m_ca[7:0]} : m_ca;
      A_EPC:   v = wr ? i_wdata : m_epc;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_cnt_base = 0; m_ticks = 0; m_cmp = 0; m_st = 32'h0040_0000;
    m_ca = 0; m_epc = 0; m_bad = 0; m_tint = 0;
  endtask

  task automatic idle();
    i_we = 0; i_waddr = 0; i_wdata = 0; i_except = 0; i_pc = 0;
    i_bd = 0; i_bad_vaddr = 0; i_int = 0;
  endtask

  // One clock: model next state from the inputs present before the edge.
  task automatic cycle();
    logic [31:0] c, n_st, n_ca, n_epc, n_bad, n_cmp;
    logic        n_tint;
    bit          flt, er, wr;
    c = m_count();
    flt = m_fault(i_except);
    er = (i_except == T_ERET);
    wr = i_we && !flt && !er;
    n_st = m_st; n_ca = m_ca; n_epc = m_epc; n_bad = m_bad; n_cmp = m_cmp;
    if (wr && i_waddr == A_CMP) begin
      n_cmp = i_wdata; n_tint = 1'b0;
    end else begin
      n_tint = m_tint || (c == m_cmp && m_cmp != 0);
    end
    n_ca[15:10] = {i_int[5] | m_tint, i_int[4:0]};
    if (flt) begin
      if (!m_st[1]) begin
        n_epc = i_bd ? i_pc - 32'd4 : i_pc;
        n_ca[31] = i_bd;
      end
      n_st[1] = 1'b1;
      n_ca[6:2] = (i_except == T_INT) ? 5'd0 : i_except[4:0];
      if (i_except == T_ADEL || i_except == T_ADES) n_bad = i_bad_vaddr;
    end else if (er) begin
      n_st[1] = 1'b0;
    end else if (wr) begin
      if (i_waddr == A_ST)  n_st = m_view(A_ST);
      if (i_waddr == A_CA)  n_ca[9:8] = i_wdata[9:8];
      if (i_waddr == A_EPC) n_epc = i_wdata;
    end
    if (wr && i_waddr == A_CNT) begin
      m_cnt_base = i_wdata; m_ticks = 0;
    end else begin
      m_ticks = m_ticks + 1;
    end
    @(posedge clk);
    m_st = n_st; m_ca = n_ca; m_epc = n_epc; m_bad = n_bad;
    m_cmp = n_cmp; m_tint = n_tint;
    #1;
  endtask

  task automatic test_reset();
    idle();
    i_raddr = A_CNT;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (o_status !== 32'h0040_0000) begin
      failures++; $display("FAIL reset_status got=%h exp=%h", o_status, 32'h0040_0000);
    end
    checks++;
    if (o_cause !== 32'd0 || o_epc !== 32'd0 || o_timer_int !== 1'b0) begin
      failures++; $display("FAIL reset_regs cause=%h epc=%h tint=%b exp=0", o_cause, o_epc, o_timer_int);
    end
    repeat (10) cycle();
    checks++;
    if (o_rdata !== 32'd5 || o_rdata !== m_count()) begin
      failures++; $display("FAIL count_after_10 got=%h exp=%h", o_rdata, 32'd5);
    end
    repeat (3) cycle();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (o_rdata !== 32'd0) begin
      failures++; $display("FAIL async_reset_count got=%h exp=0", o_rdata);
    end
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_timer();
    bit hit, seen;
    seen = 0;
    idle();
    i_we = 1; i_waddr = A_CMP; i_wdata = 32'd8;
    cycle();
    idle();
    i_raddr = A_CNT;
    for (int k = 0; k < 40 && !seen; k++) begin
      #1;
      hit = (o_rdata == 32'd8);
      cycle();
      checks++;
      if (o_timer_int !== m_tint) begin
        failures++; $display("FAIL timer_track k=%0d got=%b exp=%b", k, o_timer_int, m_tint);
      end
      if (hit) begin
        seen = 1;
        checks++;
        if (o_timer_int !== 1'b1) begin
          failures++; $display("FAIL timer_rise got=%b exp=1", o_timer_int);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL timer_timeout got=no_match exp=count_8");
    end
    cycle();
    checks++;
    if (o_cause[15] !== 1'b1 || o_timer_int !== 1'b1) begin
      failures++; $display("FAIL timer_ip7 cause15=%b tint=%b exp=1,1", o_cause[15], o_timer_int);
    end
    i_we = 1; i_waddr = A_CMP; i_wdata = 32'd100;
    cycle();
    idle();
    checks++;
    if (o_timer_int !== 1'b0) begin
      failures++; $display("FAIL timer_clear got=%b exp=0", o_timer_int);
    end
    cycle();
    checks++;
    if (o_cause[15] !== 1'b0 || o_cause !== m_ca) begin
      failures++; $display("FAIL ip7_clear got=%h exp=%h", o_cause, m_ca);
    end
  endtask

  task automatic test_count_wrap();
    idle();
    i_we = 1; i_waddr = A_CNT; i_wdata = 32'hFFFF_FFFE;
    cycle();
    idle();
    i_raddr = A_CNT;
    repeat (4) cycle();
    checks++;
    if (o_rdata !== 32'd0 || o_rdata !== m_count()) begin
      failures++; $display("FAIL count_wrap got=%h exp=%h", o_rdata, 32'd0);
    end
  endtask

  task automatic test_masks();
    idle();
    i_we = 1; i_waddr = A_ST; i_wdata = 32'hFFFF_FFFF;
    cycle();
    idle();
    i_raddr = A_ST;
    #1;
    checks++;
    if (o_rdata !== 32'h0040_FF03) begin
      failures++; $display("FAIL status_mask got=%h exp=%h", o_rdata, 32'h0040_FF03);
    end
    i_we = 1; i_waddr = A_CA; i_wdata = 32'hFFFF_FFFF;
    cycle();
    idle();
    checks++;
    if (o_cause[9:8] !== 2'b11 || o_cause !== m_ca || o_cause[31:16] !== 16'd0 || o_cause[7:0] !== 8'd0) begin
      failures++; $display("FAIL cause_mask got=%h exp=%h", o_cause, m_ca);
    end
    i_we = 1; i_waddr = A_ST; i_wdata = 32'h0000_0000;
    cycle();
    idle();
    checks++;
    if (o_status !== 32'h0040_0000) begin
      failures++; $display("FAIL status_clear got=%h exp=%h", o_status, 32'h0040_0000);
    end
  endtask

  task automatic test_exceptions();
    idle();
    i_except = T_OV; i_pc = 32'h8000_1000; i_bd = 1;
    cycle();
    idle();
    checks++;
    if (o_epc !== 32'h8000_0FFC || o_cause[31] !== 1'b1 || o_cause[6:2] !== 5'd12 || o_status[1] !== 1'b1) begin
      failures++; $display("FAIL exc_ov epc=%h cause=%h status=%h exp epc=80000ffc bd=1 code=12 exl=1", o_epc, o_cause, o_status);
    end
    i_except = T_SYS; i_pc = 32'h0000_1234; i_bd = 0;
    cycle();
    idle();
    checks++;
    if (o_epc !== 32'h8000_0FFC || o_cause[6:2] !== 5'd8 || o_cause[31] !== 1'b1) begin
      failures++; $display("FAIL exc_nested epc=%h cause=%h exp epc=80000ffc code=8", o_epc, o_cause);
    end
    i_except = T_ADEL; i_pc = 32'h0000_2000; i_bad_vaddr = 32'h0000_0003;
    cycle();
    idle();
    i_raddr = A_BAD;
    #1;
    checks++;
    if (o_rdata !== 32'h0000_0003 || o_cause[6:2] !== 5'd4) begin
      failures++; $display("FAIL exc_adel badvaddr=%h cause=%h exp 00000003 code=4", o_rdata, o_cause);
    end
    i_except = T_ERET; i_we = 1; i_waddr = A_EPC; i_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (o_epc !== 32'h8000_0FFC) begin
      failures++; $display("FAIL eret_no_fwd got=%h exp=%h", o_epc, 32'h8000_0FFC);
    end
    cycle();
    idle();
    checks++;
    if (o_status[1] !== 1'b0 || o_epc !== 32'h8000_0FFC) begin
      failures++; $display("FAIL eret status=%h epc=%h exp exl=0 epc=80000ffc", o_status, o_epc);
    end
    i_except = 32'd3; i_pc = 32'h1111_1110;
    cycle();
    idle();
    checks++;
    if (o_status !== m_st || o_epc !== m_epc || o_cause !== m_ca) begin
      failures++; $display("FAIL unknown_exc status=%h epc=%h cause=%h", o_status, o_epc, o_cause);
    end
  endtask

  task automatic test_forward();
    idle();
    i_we = 1; i_waddr = A_EPC; i_wdata = 32'hBFC0_0380; i_raddr = A_EPC;
    #1;
    checks++;
    if (o_rdata !== 32'hBFC0_0380 || o_epc !== 32'hBFC0_0380) begin
      failures++; $display("FAIL fwd_epc rdata=%h epc=%h exp=bfc00380", o_rdata, o_epc);
    end
    cycle();
    idle();
    i_we = 1; i_waddr = A_ST; i_wdata = 32'h0000_AA01; i_raddr = A_ST;
    #1;
    checks++;
    if (o_rdata !== 32'h0040_AA01 || o_status !== 32'h0040_AA01) begin
      failures++; $display("FAIL fwd_status rdata=%h status=%h exp=0040aa01", o_rdata, o_status);
    end
    cycle();
    idle();
    checks++;
    if (o_epc !== 32'hBFC0_0380 || o_status !== 32'h0040_AA01) begin
      failures++; $display("FAIL fwd_commit epc=%h status=%h", o_epc, o_status);
    end
  endtask

  task automatic test_random();
    logic [4:0]  addrs [7];
    logic [31:0] codes [10];
    addrs = '{A_BAD, A_CNT, A_CMP, A_ST, A_CA, A_EPC, 5'd3};
    codes = '{T_INT, T_ADEL, T_ADES, T_SYS, T_BP, T_RI, T_OV, T_ERET, 32'd3, 32'd7};
    for (int k = 0; k < 300; k++) begin
      i_we = ($urandom_range(0, 2) == 0);
      i_waddr = addrs[$urandom_range(0, 6)];
      i_wdata = (i_waddr == A_CMP || i_waddr == A_CNT) ? 32'($urandom_range(0, 40)) : $urandom;
      i_raddr = addrs[$urandom_range(0, 6)];
      i_int = 6'($urandom);
      i_except = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 9)] : 32'd0;
      i_pc = {$urandom, 2'b00} ;
      i_bd = 1'($urandom);
      i_bad_vaddr = $urandom;
      #1;
      checks++;
      if (o_rdata !== m_view(i_raddr) || o_status !== m_view(A_ST) ||
          o_cause !== m_view(A_CA) || o_epc !== m_view(A_EPC) || o_timer_int !== m_tint) begin
        failures++;
        $display("FAIL random k=%0d ra=%0d rdata=%h/%h st=%h/%h ca=%h/%h epc=%h/%h tint=%b/%b",
                 k, i_raddr, o_rdata, m_view(i_raddr), o_status, m_view(A_ST),
                 o_cause, m_view(A_CA), o_epc, m_view(A_EPC), o_timer_int, m_tint);
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    i_raddr = 0;
    model_reset();
    test_reset();
    test_timer();
    test_count_wrap();
    test_masks();
    test_exceptions();
    test_forward();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
